// File: rtl/sa_skew_ctrl.sv
// Sequencing controller for the N x N systolic array: buffers A and B row-pairs,
// clears the array, streams the skewed W/N wavefronts, then waits for the result.
module sa_skew_ctrl #(
  parameter int N       = 8,
  parameter int WDATA   = 4,
  parameter int TIMEOUT = 4 * N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WDATA-1:0]   a_row,
  input  logic [N*WDATA-1:0]   b_row,
  output logic                 sa_rst_n,
  output logic [N*WDATA-1:0]   sa_w,
  output logic [N*WDATA-1:0]   sa_n,
  input  logic                 sa_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [2:0]           dbg_state
);

  // Handshakes: a row-pair beat transfers on a rising edge where in_valid && in_ready;
  // the result is consumed on a rising edge where res_valid && res_ready.

  localparam int KW = $clog2(N);
  localparam int TW = $clog2(2 * N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_FEED  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   t_q, t_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [WDATA-1:0] a_buf_q [N][N];
  logic [WDATA-1:0] b_buf_q [N][N];

  logic               in_ready_q;
  logic               sa_rst_n_q;
  logic [N*WDATA-1:0] sa_w_q, sa_n_q;
  logic [N*WDATA-1:0] sa_w_d, sa_n_d;
  logic               res_valid_q;
  logic               busy_q;

  logic beat_acc;
  assign beat_acc = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          state_d = S_LOAD;
          k_d     = KW'(1);
        end
      end
      S_LOAD: begin
        if (beat_acc) begin
          if (k_q == KW'(N - 1)) begin
            state_d = S_CLEAR;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: begin
        if (t_q == TW'(2 * N - 2)) begin
          state_d = S_WAIT;
          t_d     = '0;
          cnt_d   = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts as success.
        if (sa_valid) begin
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wavefront for the upcoming cycle: lane i of W carries A[i][t-i], lane j of N carries B[t-j][j].
  always_comb begin
    sa_w_d = '0;
    sa_n_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int d = 0; d < N; d++) begin
          if (t_d == TW'(i + d)) begin
            sa_w_d[i*WDATA +: WDATA] = a_buf_q[i][d];
            sa_n_d[i*WDATA +: WDATA] = b_buf_q[d][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      sa_rst_n_q  <= 1'b0;
      sa_w_q      <= '0;
      sa_n_q      <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == S_IDLE) || (state_d == S_LOAD);
      sa_rst_n_q  <= (state_d != S_CLEAR);
      sa_w_q      <= sa_w_d;
      sa_n_q      <= sa_n_d;
      res_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Operand buffers hold no reset value; every run overwrites all N rows before use.
  always_ff @(posedge clk) begin
    if (beat_acc && !rst) begin
      for (int j = 0; j < N; j++) begin
        a_buf_q[k_q][j] <= a_row[j*WDATA +: WDATA];
        b_buf_q[k_q][j] <= b_row[j*WDATA +: WDATA];
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign sa_rst_n    = sa_rst_n_q;
  assign sa_w        = sa_w_q;
  assign sa_n        = sa_n_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sa_skew_ctrl.sv
// Directed bench for sa_skew_ctrl with a behavioural systolic-array model fed by
// the controller's wavefronts; the model's accumulators are compared with A x B.
module tb_sa_skew_ctrl;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int TO = 4 * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_row, b_row;
  logic           sa_rst_n;
  logic [N*W-1:0] sa_w, sa_n;
  logic           sa_valid;
  logic           res_valid;
  logic           res_ready;
  logic           busy;
  logic           err_timeout;
  logic [2:0]     dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  int ma [N][N];
  int mb [N][N];

  logic [2*W-1:0] acc [N][N];
  logic [W-1:0]   wp  [N][N];
  logic [W-1:0]   np_ [N][N];
  logic [W-1:0]   wi_m, ni_m;

  sa_skew_ctrl #(.N(N), .WDATA(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_row      (a_row),
    .b_row      (b_row),
    .sa_rst_n   (sa_rst_n),
    .sa_w       (sa_w),
    .sa_n       (sa_n),
    .sa_valid   (sa_valid),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .err_timeout(err_timeout),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // systolic array model, stepped on the falling edge when DUT outputs are stable
  always @(negedge clk) begin
    if (!sa_rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = '0;
          wp[i][j]  = '0;
          np_[i][j] = '0;
        end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        for (int j = N - 1; j >= 0; j--) begin
          if (j == 0) wi_m = sa_w[i*W +: W];
          else        wi_m = wp[i][j-1];
          if (i == 0) ni_m = sa_n[j*W +: W];
          else        ni_m = np_[i-1][j];
          acc[i][j] = acc[i][j] + (8'(wi_m) * 8'(ni_m));
          wp[i][j]  = wi_m;
          np_[i][j] = ni_m;
        end
    end
  end

  // scoreboard
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic fill(input bit ident);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = ident ? ((i == j) ? 1 : 0) : int'($urandom_range(1, 15));
        mb[i][j] = int'($urandom_range(1, 15));
      end
  endtask

  task automatic load_mat(input int gap);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        a_row[j*W +: W] = W'(ma[k][j]);
        b_row[j*W +: W] = W'(mb[k][j]);
      end
      in_valid = 1'b1;
      check_eq("in_ready_beat", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      if (k < N - 1)
        repeat (gap) begin
          @(negedge clk);
          check_eq("in_ready_gap", in_ready, 1);
        end
    end
    check_eq("clear_rst_n", sa_rst_n, 0);
    check_eq("clear_in_ready", in_ready, 0);
    check_eq("clear_w", sa_w, 0);
    check_eq("clear_n", sa_n, 0);
    check_eq("clear_busy", busy, 1);
  endtask

  task automatic feed_check(input int last_t);
    logic [N*W-1:0] ew, en;
    for (int t = 0; t <= last_t; t++) begin
      @(negedge clk);
      ew = '0;
      en = '0;
      if (t == 0) begin
        ew[3:0] = W'(ma[0][0]);
        en[3:0] = W'(mb[0][0]);
        check_eq("t0_rst_n", sa_rst_n, 1);
        check_eq("t0_w", sa_w, ew);
        check_eq("t0_n", sa_n, en);
      end else if (t == 1) begin
        ew[3:0] = W'(ma[0][1]);
        ew[7:4] = W'(ma[1][0]);
        en[3:0] = W'(mb[1][0]);
        en[7:4] = W'(mb[0][1]);
        check_eq("t1_w", sa_w, ew);
        check_eq("t1_n", sa_n, en);
      end else if (t == 2 * N - 2) begin
        ew[N*W-1 -: W] = W'(ma[N-1][N-1]);
        en[N*W-1 -: W] = W'(mb[N-1][N-1]);
        check_eq("tlast_w", sa_w, ew);
        check_eq("tlast_n", sa_n, en);
      end
    end
    if (last_t == 2 * N - 2) begin
      @(negedge clk);
      check_eq("wait_w", sa_w, 0);
      check_eq("wait_n", sa_n, 0);
      check_eq("wait_busy", busy, 1);
      check_eq("wait_in_ready", in_ready, 0);
      check_eq("wait_res_valid", res_valid, 0);
    end
  endtask

  task automatic finish_done(input int wcyc, input int hold);
    repeat (wcyc - 1) @(negedge clk);
    sa_valid = 1'b1;
    @(negedge clk);
    sa_valid = 1'b0;
    check_eq("done_res_valid", res_valid, 1);
    check_eq("done_in_ready", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("hold_res_valid", res_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("ack_res_valid", res_valid, 0);
    check_eq("ack_in_ready", in_ready, 1);
    check_eq("ack_busy", busy, 0);
  endtask

  task automatic check_product();
    logic [2*W-1:0] e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e = '0;
        for (int k = 0; k < N; k++) e = e + 8'(ma[i][k] * mb[k][j]);
        check_eq($sformatf("prod_%0d_%0d", i, j), acc[i][j], e);
      end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_rst_n"}, sa_rst_n, 0);
    check_eq({tag, "_w"}, sa_w, 0);
    check_eq({tag, "_n"}, sa_n, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    int wc;
    int g;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_row     = '0;
    b_row     = '0;
    sa_valid  = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_rst_n", sa_rst_n, 1);
    check_eq("post_rst_busy", busy, 0);

    // contiguous load, result held 20 cycles with beats offered
    fill(1'b0);
    load_mat(0);
    feed_check(2 * N - 2);
    finish_done(10, 20);
    check_product();

    // beats every third cycle
    fill(1'b0);
    load_mat(2);
    feed_check(2 * N - 2);
    finish_done(10, 0);
    check_product();

    // sa_valid never arrives
    fill(1'b0);
    load_mat(0);
    feed_check(2 * N - 2);
    check_eq("pre_timeout_err", err_timeout, 0);
    wc = 1;
    g  = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
      if (busy) wc++;
    end
    check_eq("wait_cycles", wc, TO);
    check_eq("timeout_err", err_timeout, 1);
    check_eq("timeout_in_ready", in_ready, 1);
    fill(1'b0);
    load_mat(0);
    feed_check(2 * N - 2);
    finish_done(10, 0);
    check_product();
    check_eq("err_sticky", err_timeout, 1);

    // reset during FEED t=5, then identity A
    fill(1'b0);
    load_mat(0);
    feed_check(5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    @(negedge clk);
    fill(1'b1);
    load_mat(0);
    feed_check(2 * N - 2);
    finish_done(10, 0);
    check_product();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_eq($sformatf("ident_%0d_%0d", i, j), acc[i][j], 8'(mb[i][j]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sa_skew_ctrl.md
# sa_skew_ctrl

Sequencing controller for the parametric systolic array (SA). It accepts matrix A and matrix B one row-pair per beat over a valid/ready handshake and buffers both matrices internally. It then clears the SA and drives the diagonally skewed W/N operand wavefronts for 2N-1 cycles. It waits for the SA's `valid` and holds a done indication until the consumer acknowledges it. The block sits between the system-side matrix source and the SA instance, replacing hand-written per-cycle stimulus.

## Interface
- `N`, 8: array dimension (N×N SA, N×N matrices); N ≥ 2.
- `WDATA`, 4: operand width; SA products/accumulations are 2*WDATA wide (handled inside SA).
- `TIMEOUT`, 4*N: max cycles spent in WAIT before flagging an error.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: one clock `clk`; reset `rst` is synchronous and active-high.
- `in_valid` in 1: row-pair beat valid.
- `in_ready` out 1: controller can accept a beat.
- `a_row` in N*WDATA: row k of A, lane j at bits [j*WDATA +: WDATA] = A[k][j] (0-based).
- `b_row` in N*WDATA: row k of B, same packing.
- `sa_rst_n` out 1: active-low clear to SA.
- `sa_w` out N*WDATA: SA West inputs, lane i drives `matrix_W[i+1]`.
- `sa_n` out N*WDATA: SA North inputs, lane j drives `matrix_N[j+1]`.
- `sa_valid` in 1: SA result-valid.
- `res_valid` out 1: SA `matrix_out` holds a complete product.
- `res_ready` in 1: consumer accepts result.
- `busy` out 1: state ≠ IDLE.
- `err_timeout` out 1: sticky; set if WAIT exceeds TIMEOUT.

## Operation
- States: IDLE, LOAD, CLEAR, FEED, WAIT, DONE.
- IDLE: `in_ready`=1. An accepted beat stores row 0 and moves the FSM to LOAD with row counter k=1.
- LOAD: `in_ready`=1. Each accepted beat stores A row k and B row k, then k++. Acceptance of the beat with k=N-1 moves the FSM to CLEAR.
- CLEAR: 1 cycle. `sa_rst_n`=0, `sa_w`/`sa_n`=0. Then goes to FEED with t=0.
- FEED: t runs 0..2N-2, one value per cycle.
  - `sa_w` lane i = A[i][t-i] when 0 ≤ t-i < N, else 0.
  - `sa_n` lane j = B[t-j][j] when 0 ≤ t-j < N, else 0.
  - After t=2N-2, goes to WAIT.
- WAIT: `sa_w`/`sa_n`=0, and a WAIT cycle counter runs.
  - `sa_valid`=1 → DONE.
  - Counter reaching TIMEOUT → set `err_timeout`, go to IDLE.
- DONE: `res_valid`=1. Stays until `res_ready`=1, then goes to IDLE in the same edge. SA is not cleared, so `matrix_out` persists until the next CLEAR.
- `in_ready`=0 in CLEAR/FEED/WAIT/DONE. Beats offered there are not accepted; the source holds them.
- Buffers: 2·N·N·WDATA registers, written only on accepted beats.
- `err_timeout` clears only on `rst`.

## Timing
- Reset (sync, `rst`=1 at edge): state=IDLE, k=0, t=0; `in_ready`=0 during reset then 1; `sa_rst_n`=0 while `rst`=1; `sa_w`=`sa_n`=0, `res_valid`=0, `busy`=0, `err_timeout`=0. Buffer contents are don't-care.
- All outputs are registered, changing only after a rising edge.
- Reset mid-operation (any state) → IDLE on that edge; the partial load is discarded.
- Latency from the last accepted beat (edge E):
  - CLEAR occupies cycle E+1.
  - FEED t=0 at E+2, t=2N-2 at E+2N.
  - WAIT from E+2N+1.
- Back-to-back loads: minimum N cycles for N beats.
- `in_valid` with `in_ready`=0 has no effect.
- `res_valid` and `res_ready` both 1 → next cycle IDLE, with `in_ready`=1 and `res_valid`=0.
- `sa_valid` arriving in the same cycle the timeout count is reached → valid wins (DONE, no error).

## Test plan
- N=8, random A,B in 1..15, 8 contiguous beats → FEED cycle t=0 shows W=[A00,0…], N=[B00,0…]. t=1 shows W=[A01,A10,0…], N=[B10,B01,0…]. `res_valid` rises, and SA `matrix_out` equals A×B at all 64 indices.
- Gapped `in_valid` (beats every 3rd cycle) → same product; `in_ready` stays 1 through LOAD; CLEAR follows exactly 1 cycle after the 8th accept.
- Hold `res_ready`=0 for 20 cycles in DONE → `res_valid` stays 1, `in_ready`=0, offered beats are not accepted; `res_ready`=1 → IDLE next cycle.
- Tie `sa_valid`=0 → after 32 WAIT cycles `err_timeout`=1 and state is IDLE. A following load/compute still runs, and `err_timeout` stays 1 until `rst`.
- Assert `rst` for 1 cycle during FEED t=5 → next cycle all outputs at reset values, `busy`=0. A fresh 8-beat load then yields the correct product with no residue from the aborted run.
- Identity A with random B → `matrix_out` equals B zero-extended to 2*WDATA bits.
